// File: rtl/ram_clear_seq.sv
// Single-port synchronous RAM with a built-in sequencer that writes INIT_VAL to every word.
// Latency: read data and rd_valid one clock after a read access; a clear takes 2**ADDR_W clocks.
// Backpressure: busy is high while clearing; accesses and clear_req presented while busy are dropped.
module ram_clear_seq #(
  parameter int                DATA_W   = 10,
  parameter int                ADDR_W   = 10,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk_reset,
  input  logic              reset,
  input  logic              chip_select,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic              clear_req,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic              busy_q;
  logic              clear_done_q;

  // The array itself has no reset; only the clear sequence initialises it.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Single write port: the sequencer owns it while clearing, masked user writes otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = (mem[address] & ~wr_mask) | (data_in & wr_mask);
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = INIT_VAL;
    end else if (chip_select && write) begin
      mem_we    = 1'b1;
    end
  end

  // Storage array write.
  always_ff @(posedge clk_reset) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Control FSM with registered read data, read strobe, busy and clear-done pulse.
  always_ff @(posedge clk_reset or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b1;
      clear_done_q <= 1'b0;
    end else begin
      rd_valid_q   <= 1'b0;
      clear_done_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          // DEPTH is a power of two, so the last location is the all-ones address.
          if (clr_addr_q == '1) begin
            state_q      <= ST_READY;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
            clr_addr_q   <= '0;
          end else begin
            clr_addr_q   <= clr_addr_q + 1'b1;
          end
        end
        ST_READY: begin
          if (chip_select && !write) begin
            data_out_q <= mem[address];
            rd_valid_q <= 1'b1;
          end
          // An access in the same cycle still completes; the clear starts next cycle.
          if (clear_req) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_ram_clear_seq.sv
// Bench for ram_clear_seq: default 1024x10 instance plus a 16x16 instance with INIT_VAL=0x155.
// Read expectations go into per-instance queues and are compared when rd_valid is seen.
// Inputs change after the rising edge; outputs are sampled on the falling edge.
module tb_ram_clear_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: DATA_W=10, ADDR_W=10, INIT_VAL=0
  logic       rst_a, cs_a, wr_a, clr_a;
  logic [9:0] addr_a, din_a, mask_a, dout_a;
  logic       vld_a, busy_a, done_a;

  // instance B: DATA_W=16, ADDR_W=4, INIT_VAL=0x155
  logic        rst_b, cs_b, wr_b, clr_b;
  logic [3:0]  addr_b;
  logic [15:0] din_b, mask_b, dout_b;
  logic        vld_b, busy_b, done_b;

  ram_clear_seq #(.DATA_W(10), .ADDR_W(10), .INIT_VAL(10'h000)) u_dut_a (
    .clk_reset(clk), .reset(rst_a), .chip_select(cs_a), .write(wr_a),
    .address(addr_a), .data_in(din_a), .wr_mask(mask_a), .clear_req(clr_a),
    .data_out(dout_a), .rd_valid(vld_a), .busy(busy_a), .clear_done(done_a)
  );

  ram_clear_seq #(.DATA_W(16), .ADDR_W(4), .INIT_VAL(16'h0155)) u_dut_b (
    .clk_reset(clk), .reset(rst_b), .chip_select(cs_b), .write(wr_b),
    .address(addr_b), .data_in(din_b), .wr_mask(mask_b), .clear_req(clr_b),
    .data_out(dout_b), .rd_valid(vld_b), .busy(busy_b), .clear_done(done_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0]  mdl [1024];
  logic [9:0]  qa [$];
  logic [15:0] qb [$];

  typedef struct {
    logic       cs;
    logic       wr;
    logic [9:0] addr;
    logic [9:0] data;
    logic [9:0] mask;
    logic       exp_vld;
    logic [9:0] exp_dout;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard for instance A
  always @(negedge clk) begin
    if (rst_a === 1'b1 && vld_a === 1'b1) begin
      if (qa.size() == 0) chk("a_spurious_rd_valid", 32'(vld_a), 32'd0);
      else                chk("a_read_data", 32'(dout_a), 32'(qa.pop_front()));
    end
  end

  // scoreboard for instance B
  always @(negedge clk) begin
    if (rst_b === 1'b1 && vld_b === 1'b1) begin
      if (qb.size() == 0) chk("b_spurious_rd_valid", 32'(vld_b), 32'd0);
      else                chk("b_read_data", 32'(dout_b), 32'(qb.pop_front()));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    cs_a = 1'b0; wr_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic write_a(input int a, input logic [9:0] d, input logic [9:0] m, input bit taken);
    cs_a = 1'b1; wr_a = 1'b1; addr_a = 10'(a); din_a = d; mask_a = m;
    tick();
    idle_a();
    if (taken) mdl[a] = (mdl[a] & ~m) | (d & m);
  endtask

  task automatic read_a(input int a);
    cs_a = 1'b1; wr_a = 1'b0; addr_a = 10'(a);
    qa.push_back(mdl[a]);
    tick();
    idle_a();
  endtask

  task automatic drain_a(input string tag);
    tick();
    tick();
    chk({tag, "_queue_drained"}, 32'(qa.size()), 32'd0);
  endtask

  // Called right after the edge that makes busy high; counts busy cycles, then checks the done pulse.
  task automatic clear_check_a(input string tag, input int exp_len);
    int len;
    len = 0;
    @(negedge clk);
    while (busy_a === 1'b1 && len < 5000) begin
      len++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, 32'(len), 32'(exp_len));
    chk({tag, "_clear_done_pulse"}, 32'(done_a), 32'd1);
    @(negedge clk);
    chk({tag, "_clear_done_one_cycle"}, 32'(done_a), 32'd0);
    chk({tag, "_busy_low_after"}, 32'(busy_a), 32'd0);
    tick();
  endtask

  initial begin
    int len;
    idle_a();
    addr_a = '0; din_a = '0; mask_a = '0;
    cs_b = 1'b0; wr_b = 1'b0; clr_b = 1'b0; addr_b = '0; din_b = '0; mask_b = '0;
    rst_a = 1'b0; rst_b = 1'b0;
    for (int i = 0; i < 1024; i++) mdl[i] = 10'h000;

    // masked-write / read vectors on address 5 and 6 (expected values hand-derived)
    vt[0]  = '{1'b1, 1'b1, 10'd5, 10'h3FF, 10'h3FF, 1'b0, 10'h3E8};
    vt[1]  = '{1'b1, 1'b0, 10'd5, 10'h000, 10'h000, 1'b1, 10'h3FF};
    vt[2]  = '{1'b1, 1'b1, 10'd5, 10'h000, 10'h00F, 1'b0, 10'h3FF};
    vt[3]  = '{1'b1, 1'b0, 10'd5, 10'h000, 10'h000, 1'b1, 10'h3F0};
    vt[4]  = '{1'b1, 1'b1, 10'd5, 10'h123, 10'h000, 1'b0, 10'h3F0};
    vt[5]  = '{1'b1, 1'b0, 10'd5, 10'h000, 10'h000, 1'b1, 10'h3F0};
    vt[6]  = '{1'b0, 1'b1, 10'd5, 10'h000, 10'h3FF, 1'b0, 10'h3F0};
    vt[7]  = '{1'b1, 1'b0, 10'd5, 10'h000, 10'h000, 1'b1, 10'h3F0};
    vt[8]  = '{1'b1, 1'b1, 10'd6, 10'h2AA, 10'h3FF, 1'b0, 10'h3F0};
    vt[9]  = '{1'b1, 1'b1, 10'd6, 10'h155, 10'h0F0, 1'b0, 10'h3F0};
    vt[10] = '{1'b1, 1'b0, 10'd6, 10'h000, 10'h000, 1'b1, 10'h25A};
    vt[11] = '{1'b1, 1'b0, 10'd4, 10'h000, 10'h000, 1'b1, 10'h004};

    repeat (3) tick();

    // reset state
    chk("rst_busy",       32'(busy_a), 32'd1);
    chk("rst_rd_valid",   32'(vld_a),  32'd0);
    chk("rst_data_out",   32'(dout_a), 32'd0);
    chk("rst_clear_done", 32'(done_a), 32'd0);
    chk("rst_b_busy",     32'(busy_b), 32'd1);
    chk("rst_b_data_out", 32'(dout_b), 32'd0);

    // 1: clear after reset release, then everything reads as 0
    rst_a = 1'b1;
    clear_check_a("t1", 1024);
    for (int i = 0; i < 1024; i++) read_a(i);
    drain_a("t1");

    // 2: address-as-data fill, back-to-back reads of 1..1000
    for (int k = 0; k < 1024; k++) write_a(k, 10'(k), 10'h3FF, 1'b1);
    for (int k = 1; k <= 1000; k++) read_a(k);
    drain_a("t2");

    // 3: table of masked writes, reads and idle cycles
    for (int i = 0; i < 12; i++) begin
      cs_a = vt[i].cs; wr_a = vt[i].wr; addr_a = vt[i].addr;
      din_a = vt[i].data; mask_a = vt[i].mask;
      if (vt[i].cs && !vt[i].wr) qa.push_back(vt[i].exp_dout);
      if (vt[i].cs && vt[i].wr)
        mdl[vt[i].addr] = (mdl[vt[i].addr] & ~vt[i].mask) | (vt[i].data & vt[i].mask);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t3_vec%0d_rd_valid", i), 32'(vld_a), 32'(vt[i].exp_vld));
      if (!vt[i].exp_vld) chk($sformatf("t3_vec%0d_hold", i), 32'(dout_a), 32'(vt[i].exp_dout));
      idle_a();
    end
    tick();
    drain_a("t3");

    // 4: clear request on a filled array; a write during busy is dropped
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("t4_busy_after_req", 32'(busy_a), 32'd1);
    write_a(7, 10'd99, 10'h3FF, 1'b0);
    clear_check_a("t4", 1023);
    for (int i = 0; i < 1024; i++) mdl[i] = 10'h000;
    for (int i = 0; i < 1024; i++) read_a(i);
    drain_a("t4");

    // 5: reset when clr_addr reaches 500, then a full clear restarts
    write_a(900, 10'h2AB, 10'h3FF, 1'b1);
    read_a(900);
    drain_a("t5_pre");
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    repeat (500) tick();
    chk("t5_data_out_held", 32'(dout_a), 32'h2AB);
    chk("t5_busy_mid",      32'(busy_a), 32'd1);
    rst_a = 1'b0;
    #1;
    chk("t5_rst_data_out", 32'(dout_a), 32'd0);
    chk("t5_rst_rd_valid", 32'(vld_a),  32'd0);
    chk("t5_rst_busy",     32'(busy_a), 32'd1);
    tick();
    rst_a = 1'b1;
    clear_check_a("t5", 1024);
    for (int i = 0; i < 1024; i++) mdl[i] = 10'h000;
    read_a(0); read_a(499); read_a(500); read_a(900); read_a(1023);
    drain_a("t5");

    // 6: small instance, INIT_VAL 0x155, clear_req during busy is ignored
    rst_b = 1'b1;
    len = 0;
    @(negedge clk);
    while (busy_b === 1'b1 && len < 100) begin
      len++;
      @(posedge clk);
      #1;
      clr_b = (len == 3);
      @(negedge clk);
    end
    clr_b = 1'b0;
    chk("t6_busy_len",       32'(len),    32'd16);
    chk("t6_clear_done",     32'(done_b), 32'd1);
    @(negedge clk);
    chk("t6_clear_done_one", 32'(done_b), 32'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      cs_b = 1'b1; wr_b = 1'b0; addr_b = 4'(i);
      qb.push_back(16'h0155);
      tick();
    end
    cs_b = 1'b0;
    tick();
    tick();
    chk("t6_queue_drained",   32'(qb.size()), 32'd0);
    chk("t6_busy_stays_low",  32'(busy_b),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
